// File: rtl/irq_capture_4.sv
// irq_capture_4: four-channel interrupt capture stage that feeds a 4-to-2 priority encoder.
// Raw request lines are edge-detected and held in sticky pending bits until they are
// acknowledged by channel index. A mask gates only the visible pend output. Overflow
// and bad-acknowledge conditions are flagged.
// Optional feature: define IRQ_CAPTURE_SYNC_EN to put a 2-flop synchronizer in front of
// the edge detector. Without it, irq_in must already be synchronous to clk.
module irq_capture_4 #(
   parameter logic [3:0] MASK_RST = 4'b0000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] irq_in,
   input  logic       mask_we,
   input  logic [3:0] mask_wdata,
   input  logic       ack,
   input  logic [1:0] ack_id,
   output logic [3:0] pend,
   output logic       irq_req,
   output logic [3:0] mask,
   output logic [3:0] ovf,
   output logic       ack_err
);

   logic [3:0] s;
   logic [3:0] s_d_q;
   logic [3:0] s_d_d;
   logic [3:0] edge_det;
   logic [3:0] pend_raw_q;
   logic [3:0] pend_raw_d;
   logic [3:0] ovf_q;
   logic [3:0] ovf_d;
   logic [3:0] mask_q;
   logic [3:0] mask_d;
   logic       ack_err_q;
   logic       ack_err_d;
   logic       ack_valid;
   logic [3:0] clr_vec;

`ifdef IRQ_CAPTURE_SYNC_EN
   logic [3:0] sync1_q;
   logic [3:0] sync2_q;

   // Two-flop synchronizer bringing the asynchronous request lines into the clk domain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 4'b0000;
         sync2_q <= 4'b0000;
      end else begin
         sync1_q <= irq_in;
         sync2_q <= sync1_q;
      end
   end

   assign s = sync2_q;
`else
   assign s = irq_in;
`endif

   // Edge history starts at zero so a line held high across reset release reads as one rising edge
   always_comb begin
      s_d_d    = s;
      edge_det = s & ~s_d_q;
   end

   // Acknowledge decode: an ack only counts when the addressed channel is actually pending
   always_comb begin
      ack_valid        = ack & pend_raw_q[ack_id];
      ack_err_d        = ack & ~pend_raw_q[ack_id];
      clr_vec          = 4'b0000;
      if (ack_valid) begin
         clr_vec[ack_id] = 1'b1;
      end
   end

   // Pending and overflow next state; a same-cycle edge beats a clear and leaves ovf untouched
   always_comb begin
      pend_raw_d = pend_raw_q;
      ovf_d      = ovf_q;
      for (int i = 0; i < 4; i++) begin
         if (edge_det[i]) begin
            pend_raw_d[i] = 1'b1;
            if (pend_raw_q[i] && !clr_vec[i]) begin
               ovf_d[i] = 1'b1;
            end
         end else if (clr_vec[i]) begin
            pend_raw_d[i] = 1'b0;
            ovf_d[i]      = 1'b0;
         end
      end
   end

   // Mask register update, independent of any acknowledge in the same cycle
   always_comb begin
      mask_d = mask_q;
      if (mask_we) begin
         mask_d = mask_wdata;
      end
   end

   // State registers for edge history, pending bits, overflow, mask and the ack error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_d_q      <= 4'b0000;
         pend_raw_q <= 4'b0000;
         ovf_q      <= 4'b0000;
         mask_q     <= MASK_RST;
         ack_err_q  <= 1'b0;
      end else begin
         s_d_q      <= s_d_d;
         pend_raw_q <= pend_raw_d;
         ovf_q      <= ovf_d;
         mask_q     <= mask_d;
         ack_err_q  <= ack_err_d;
      end
   end

   // Outputs come from registers only, so there is no input-to-output combinational path
   always_comb begin
      pend    = pend_raw_q & ~mask_q;
      irq_req = |(pend_raw_q & ~mask_q);
      mask    = mask_q;
      ovf     = ovf_q;
      ack_err = ack_err_q;
   end

endmodule

// File: tb/tb_irq_capture_4.sv
// Self-checking bench for irq_capture_4: a table of directed vectors plus hand-written
// sequences for the edge/ack collision and the asynchronous reset.
module tb_irq_capture_4;

`ifdef IRQ_CAPTURE_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic [3:0] irq_in;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic       ack;
   logic [1:0] ack_id;
   logic [3:0] pend;
   logic       irq_req;
   logic [3:0] mask;
   logic [3:0] ovf;
   logic       ack_err;

   int tests;
   int fails;

   typedef struct {
      logic [3:0] irq;
      logic       mwe;
      logic [3:0] mwdata;
      logic       ak;
      logic [1:0] akid;
      logic       settle;
      logic [3:0] exp_pend;
      logic       exp_req;
      logic [3:0] exp_mask;
      logic [3:0] exp_ovf;
      logic       exp_err;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs[NVEC];

   irq_capture_4 #(.MASK_RST(4'b0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .irq_in     (irq_in),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ack        (ack),
      .ack_id     (ack_id),
      .pend       (pend),
      .irq_req    (irq_req),
      .mask       (mask),
      .ovf        (ovf),
      .ack_err    (ack_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [3:0] irq, input logic mwe, input logic [3:0] mwdata,
                               input logic ak, input logic [1:0] akid, input logic settle,
                               input logic [3:0] ep, input logic er, input logic [3:0] em,
                               input logic [3:0] eo, input logic ee);
      vec_t v;
      v.irq = irq; v.mwe = mwe; v.mwdata = mwdata; v.ak = ak; v.akid = akid;
      v.settle = settle; v.exp_pend = ep; v.exp_req = er; v.exp_mask = em;
      v.exp_ovf = eo; v.exp_err = ee;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic [3:0] ep, input logic er,
                              input logic [3:0] em, input logic [3:0] eo, input logic ee);
      cmp({tag, ".pend"}, pend, ep);
      cmp({tag, ".irq_req"}, {3'b000, irq_req}, {3'b000, er});
      cmp({tag, ".mask"}, mask, em);
      cmp({tag, ".ovf"}, ovf, eo);
      cmp({tag, ".ack_err"}, {3'b000, ack_err}, {3'b000, ee});
   endtask

   // One clock with the vector's strobes, then extra clocks (strobes dropped) to cover synchronizer latency
   task automatic applyStimulus(input vec_t v);
      irq_in     = v.irq;
      mask_we    = v.mwe;
      mask_wdata = v.mwdata;
      ack        = v.ak;
      ack_id     = v.akid;
      tick();
      mask_we = 1'b0;
      ack     = 1'b0;
      if (v.settle) begin
         repeat (SYNC_LAT) tick();
      end
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst_n      = 1'b0;
      irq_in     = 4'b0000;
      mask_we    = 1'b0;
      mask_wdata = 4'b0000;
      ack        = 1'b0;
      ack_id     = 2'd0;

      //          irq     mwe mwdata  ack id settle  pend   req mask    ovf     err
      vecs[0]  = mk(4'b0100, 0, 4'b0000, 0, 2'd0, 1, 4'b0100, 1, 4'b0000, 4'b0000, 0);
      vecs[1]  = mk(4'b0100, 0, 4'b0000, 0, 2'd0, 0, 4'b0100, 1, 4'b0000, 4'b0000, 0);
      vecs[2]  = mk(4'b0000, 0, 4'b0000, 1, 2'd2, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      vecs[3]  = mk(4'b1001, 0, 4'b0000, 0, 2'd0, 1, 4'b1001, 1, 4'b0000, 4'b0000, 0);
      vecs[4]  = mk(4'b1001, 0, 4'b0000, 1, 2'd3, 0, 4'b0001, 1, 4'b0000, 4'b0000, 0);
      vecs[5]  = mk(4'b0000, 0, 4'b0000, 1, 2'd3, 0, 4'b0001, 1, 4'b0000, 4'b0000, 1);
      vecs[6]  = mk(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 4'b0001, 1, 4'b0000, 4'b0000, 0);
      vecs[7]  = mk(4'b0000, 0, 4'b0000, 1, 2'd0, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      vecs[8]  = mk(4'b0000, 1, 4'b0010, 0, 2'd0, 0, 4'b0000, 0, 4'b0010, 4'b0000, 0);
      vecs[9]  = mk(4'b0010, 0, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 4'b0010, 4'b0000, 0);
      vecs[10] = mk(4'b0010, 1, 4'b0000, 0, 2'd0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
      vecs[11] = mk(4'b0000, 0, 4'b0000, 0, 2'd0, 1, 4'b0010, 1, 4'b0000, 4'b0000, 0);
      vecs[12] = mk(4'b0010, 0, 4'b0000, 0, 2'd0, 1, 4'b0010, 1, 4'b0000, 4'b0010, 0);
      vecs[13] = mk(4'b0010, 0, 4'b0000, 1, 2'd1, 0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      vecs[14] = mk(4'b0000, 0, 4'b0000, 0, 2'd0, 1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
      vecs[15] = mk(4'b0001, 0, 4'b0000, 0, 2'd0, 1, 4'b0001, 1, 4'b0000, 4'b0000, 0);
      vecs[16] = mk(4'b0000, 1, 4'b1000, 1, 2'd0, 1, 4'b0000, 0, 4'b1000, 4'b0000, 0);
      vecs[17] = mk(4'b0001, 1, 4'b0000, 0, 2'd0, 1, 4'b0001, 1, 4'b0000, 4'b0000, 0);

      repeat (3) tick();
      checkOutput("in_reset", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
      rst_n = 1'b1;
      tick();
      checkOutput("after_reset", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp_pend, vecs[i].exp_req,
                     vecs[i].exp_mask, vecs[i].exp_ovf, vecs[i].exp_err);
      end

      // ch0 is pending with its line high; drop it so a fresh edge can collide with an ack of ch0
      irq_in = 4'b0000;
      tick();
      repeat (SYNC_LAT) tick();
      irq_in = 4'b0001;
      repeat (SYNC_LAT) tick();
      ack    = 1'b1;
      ack_id = 2'd0;
      tick();
      ack = 1'b0;
      checkOutput("edge_vs_ack", 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0);
      tick();
      checkOutput("edge_vs_ack_next", 4'b0001, 1'b1, 4'b0000, 4'b0000, 1'b0);

      // Fill every channel and create an overflow on ch0 before hitting reset
      irq_in = 4'b1111;
      tick();
      repeat (SYNC_LAT) tick();
      checkOutput("all_pend", 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0);
      irq_in = 4'b0000;
      tick();
      repeat (SYNC_LAT) tick();
      irq_in = 4'b0001;
      tick();
      repeat (SYNC_LAT) tick();
      checkOutput("pre_reset_ovf", 4'b1111, 1'b1, 4'b0000, 4'b0001, 1'b0);

      // Asynchronous reset mid-cycle: outputs must clear before any clock edge
      #2;
      rst_n  = 1'b0;
      irq_in = 4'b1000;
      #1;
      checkOutput("async_reset", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
      tick();
      rst_n = 1'b1;
      #1;
      checkOutput("release", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
      repeat (SYNC_LAT) tick();
      checkOutput("release_latency", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
      tick();
      checkOutput("held_high_edge", 4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/irq_capture_4.md
# irq_capture_4

Four-channel interrupt request capture stage that sits directly upstream of the 4-to-2 priority encoder. It synchronizes four raw request lines, detects rising edges, and holds each event in a sticky pending bit until it is acknowledged by encoded channel index. It applies a programmable mask and presents the result on `pend`, which drives the encoder's 4-bit request input. Overflow (an edge arriving while the channel is already pending) and bad-acknowledge conditions are flagged.

## Interface
- `MASK_RST`, default 4'b0000: reset value of the mask register (1 = channel masked).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `irq_in`  in  4  raw request lines, asynchronous to `clk`.
- `mask_we`  in  1  mask write strobe.
- `mask_wdata`  in  4  new mask value, written when `mask_we`=1.
- `ack`  in  1  acknowledge strobe, one cycle per acknowledged event.
- `ack_id`  in  2  channel index being acknowledged (encoder output format).
- `pend`  out  4  `pend_raw & ~mask`; feeds the encoder `d_in`.
- `irq_req`  out  1  `|pend`.
- `mask`  out  4  current mask register.
- `ovf`  out  4  sticky per-channel overflow flags.
- `ack_err`  out  1  registered one-cycle pulse on an invalid acknowledge.

## Operation
- Reset (async assert, sync release): `pend_raw`=0, `ovf`=0, `ack_err`=0, `mask`=`MASK_RST`, all synchronizer and edge-history flops = 0.
- Edge detect per channel: `edge[i] = s[i] & ~s_d[i]`, where `s` is the synchronized line and `s_d` is its one-cycle-delayed copy.
- A line held high across reset release counts as one rising edge.
- Pending bit `i`:
  - Set on `edge[i]`.
  - Cleared on `ack && ack_id==i`.
  - If a set and a clear hit the same channel in the same cycle, **set wins**: `pend_raw[i]` stays 1 and `ovf[i]` is not touched.
- Overflow `ovf[i]`:
  - Set when `edge[i]` arrives while `pend_raw[i]`=1 and there is no same-cycle ack of `i`.
  - Cleared by an ack of `i`.
  - Set on the same cycle as an ack of `i` is not possible, because set-wins applies.
- Masking:
  - The mask gates only the `pend` output.
  - Edges on masked channels are still latched into `pend_raw` and still flag overflow.
  - Unmasking a channel that is already pending raises `pend[i]` on the cycle after the mask write.
- Acknowledge:
  - Clears `pend_raw[ack_id]` whether or not that channel is masked.
  - If `pend_raw[ack_id]`=0, then `ack_err` pulses high for exactly one cycle and no state changes.
- Mask write: `mask <= mask_wdata` when `mask_we`=1. A mask write and an ack in the same cycle are independent of each other.
- Several channels may be pending at once. This block does no prioritization; that is the encoder's job.

## Timing
- With synchronizer: `irq_in[i]` first sampled high at clock edge E0 → `s[i]` high after E1 → `pend_raw[i]` high after E2. Request-to-`pend` latency is 3 edges.
- `pend`, `irq_req` and `mask` are combinational from registers only; there is no input-to-output combinational path.
- Ack at edge Ek clears the bit, so `pend[i]`=0 from after Ek. `ack_err` is high for the cycle following Ek.
- Minimum pulse width on `irq_in`: 2 `clk` periods when the synchronizer is compiled in, otherwise 1.
- Back-to-back edges on one channel need the line low for at least one sampled cycle between them.

## Configuration
- Macro: `IRQ_CAPTURE_SYNC_EN`.
- Defined: a 2-flop synchronizer sits in front of the edge detector. Latency is as stated under Timing (`pend` high after E2).
- Undefined: `irq_in` must already be synchronous to `clk`, and `s = irq_in` directly. `pend_raw[i]` is set at E0, the first edge that samples the line high. All other behaviour is identical.

## Test plan
- Reset with `MASK_RST`=0, `irq_in`=0 → `pend`=0, `ovf`=0, `ack_err`=0. Pulse `irq_in[2]` high for 3 cycles → `pend`=4'b0100 after E2, `irq_req`=1. Ack with `ack_id`=2 → `pend`=0.
- Raise `irq_in[3]` and `irq_in[0]` together → `pend`=4'b1001. Ack 3 → `pend`=4'b0001. Ack 3 again → `ack_err` one-cycle pulse, `pend` unchanged.
- Write `mask`=4'b0010, then pulse `irq_in[1]` → `pend`=0 while `pend_raw[1]`=1. Write `mask`=0 → `pend`=4'b0010 on the next cycle.
- With `pend_raw[1]`=1, send a second edge on `irq_in[1]` → `ovf`=4'b0010. Ack 1 → `ovf`=0 and `pend`=0.
- Make an edge on channel 0 coincide with an ack of channel 0 → `pend[0]` stays 1, no `ovf`, no `ack_err`.
- Assert `rst_n`=0 mid-operation while `pend`=4'b1111 and `ovf`≠0 → all outputs return to reset values immediately, without waiting for a clock edge. Release reset with `irq_in[3]` held high → `pend[3]` sets after the normal latency.
